// File: rtl/byte_addr_load_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : byte_addr_load_unit_if
// Description : Load-request, response and word-memory signals of the
//               byte-addressed load unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_addr_load_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_rd_en;
    logic [29:0] mem_word_addr;
    logic [31:0] mem_rd_data;

    // The load unit itself
    modport slave (
        input  req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_word_addr
    );

    // Datapath plus memory side facing the unit
    modport master (
        output req_valid, req_addr, req_size, req_signed, rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_word_addr
    );
endinterface
`default_nettype wire

// File: rtl/byte_addr_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : byte_addr_load_unit
// Description : Byte/halfword/word loads over a 1-cycle-latency word memory,
//               including two-read accesses that span a word boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_addr_load_unit #(
    parameter int ALLOW_UNALIGNED = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    byte_addr_load_unit_if.slave    bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD_LO = 3'd1;
    localparam logic [2:0] c_RD_HI = 3'd2;
    localparam logic [2:0] c_MERGE = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_req_illegal;
    logic [2:0]  w_nbytes;
    logic        w_span;
    logic [31:0] w_merge_lo;
    logic [31:0] w_merge_hi;
    logic [4:0]  w_shamt;
    logic [31:0] w_aligned;
    logic [31:0] w_result;

    assign w_req_illegal = (bus.req_size == 2'd3) ||
                           ((ALLOW_UNALIGNED == 0) &&
                            (((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                             ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0))));

    assign w_nbytes = (r_size == 2'd0) ? 3'd1 : ((r_size == 2'd1) ? 3'd2 : 3'd4);
    assign w_span   = ({1'b0, r_addr[1:0]} + w_nbytes) > 3'd4;

    // In MERGE the memory is returning the last word: the high word when spanning, else the only one
    assign w_merge_lo = w_span ? r_lo : bus.mem_rd_data;
    assign w_merge_hi = w_span ? bus.mem_rd_data : r_hi;
    assign w_shamt    = {r_addr[1:0], 3'b000};
    assign w_aligned  = 32'({w_merge_hi, w_merge_lo} >> w_shamt);

    always_comb begin
        w_result = w_aligned;
        case (r_size)
            2'd0:    w_result = {{24{r_signed & w_aligned[7]}},  w_aligned[7:0]};
            2'd1:    w_result = {{16{r_signed & w_aligned[15]}}, w_aligned[15:0]};
            default: w_result = w_aligned;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        if (w_req_illegal) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                            r_state    <= c_RESP;
                        end else begin
                            r_state <= c_RD_LO;
                        end
                    end
                end
                c_RD_LO: r_state <= w_span ? c_RD_HI : c_MERGE;
                c_RD_HI: begin
                    r_lo    <= bus.mem_rd_data;
                    r_state <= c_MERGE;
                end
                c_MERGE: begin
                    r_lo       <= w_merge_lo;
                    r_hi       <= w_merge_hi;
                    r_rsp_data <= w_result;
                    r_rsp_err  <= 1'b0;
                    r_state    <= c_RESP;
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (r_state == c_IDLE);
    assign bus.rsp_valid     = (r_state == c_RESP);
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.mem_rd_en     = (r_state == c_RD_LO) || (r_state == c_RD_HI);
    // The +1 wraps naturally in 30 bits, so the top word is followed by word 0
    assign bus.mem_word_addr = (r_state == c_RD_LO) ? r_addr[31:2] :
                               (r_state == c_RD_HI) ? (r_addr[31:2] + 30'd1) : 30'd0;

endmodule
`default_nettype wire

// File: tb/tb_byte_addr_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_addr_load_unit
// Description : Randomised and directed bench for the permissive and strict
//               (no unaligned) variants, driven with identical requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_addr_load_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   addr_viol = 0;
    logic [29:0] rd_q0[$];
    logic [29:0] rd_q1[$];

    always #5 clk = ~clk;

    byte_addr_load_unit_if bus0 ();
    byte_addr_load_unit_if bus1 ();

    assign bus1.req_valid  = bus0.req_valid;
    assign bus1.req_addr   = bus0.req_addr;
    assign bus1.req_size   = bus0.req_size;
    assign bus1.req_signed = bus0.req_signed;
    assign bus1.rsp_ready  = bus0.rsp_ready;

    byte_addr_load_unit #(.ALLOW_UNALIGNED(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    byte_addr_load_unit #(.ALLOW_UNALIGNED(0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    function automatic logic [31:0] mem_fn(input logic [29:0] w);
        case (w)
            30'h0:        return 32'h44332211;
            30'h1:        return 32'h88776655;
            30'h2:        return 32'hCCBBAA99;
            30'h3FFFFFFF: return 32'hDDCCBBAA;
            default:      return {2'b10, w} ^ 32'hA5C31E77;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus0.mem_rd_en) begin
            bus0.mem_rd_data <= mem_fn(bus0.mem_word_addr);
            rd_q0.push_back(bus0.mem_word_addr);
        end
        if (bus1.mem_rd_en) begin
            bus1.mem_rd_data <= mem_fn(bus1.mem_word_addr);
            rd_q1.push_back(bus1.mem_word_addr);
        end
    end

    always @(negedge clk) begin
        if (!reset && !bus0.mem_rd_en && bus0.mem_word_addr != 30'd0) addr_viol <= addr_viol + 1;
    end

    // Byte-by-byte reference: gather each addressed byte from the memory image
    function automatic void ref_load(input int allow, input logic [31:0] addr, input logic [1:0] size,
                                     input logic sgn, output logic [31:0] data, output logic err,
                                     output int lat, output int nrd,
                                     output logic [29:0] wa0, output logic [29:0] wa1);
        int nb;
        logic [31:0] a;
        logic [31:0] last;
        logic [31:0] word;
        nb   = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
        err  = (size == 2'd3) || (allow == 0 && (addr % nb) != 0);
        data = 32'd0;
        nrd  = 0;
        wa0  = 30'd0;
        wa1  = 30'd0;
        lat  = 1;
        if (err) return;
        for (int i = 0; i < nb; i++) begin
            a    = addr + i;
            word = mem_fn(a[31:2]);
            data[8*i +: 8] = word[8*a[1:0] +: 8];
        end
        if (sgn && nb < 4 && data[8*nb-1]) data = data | (32'hFFFFFFFF << (8*nb));
        last = addr + nb - 1;
        wa0  = addr[31:2];
        if (last[31:2] != addr[31:2]) begin
            nrd = 2; wa1 = last[31:2]; lat = 4;
        end else begin
            nrd = 1; lat = 3;
        end
    endfunction

    task automatic do_req(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          output logic [31:0] d0, output logic e0, output int l0,
                          output logic [31:0] d1, output logic e1, output int l1,
                          output bit timeout);
        int guard = 0;
        int c = 1;
        timeout = 0; l0 = 0; l1 = 0;
        while (!bus0.req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) timeout = 1;
        bus0.req_valid  = 1'b1;
        bus0.req_addr   = addr;
        bus0.req_size   = size;
        bus0.req_signed = sgn;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        rd_q0.delete();
        rd_q1.delete();
        while (1) begin
            if (bus0.rsp_valid && l0 == 0) l0 = c;
            if (bus1.rsp_valid && l1 == 0) l1 = c;
            if (l0 != 0 && l1 != 0) break;
            if (c >= 20) begin timeout = 1; break; end
            @(posedge clk); #1; c++;
        end
        d0 = bus0.rsp_data; e0 = bus0.rsp_err;
        d1 = bus1.rsp_data; e1 = bus1.rsp_err;
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_data !== 32'd0 ||
            bus0.rsp_err !== 1'b0 || bus0.mem_rd_en !== 1'b0 || bus0.mem_word_addr !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b rd_en=%b waddr=%h, need 1 0 0 0 0 0",
                     bus0.req_ready, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.mem_rd_en, bus0.mem_word_addr);
        end
        n_checks++;
        if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus1.rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state_strict: ready=%b valid=%b data=%h", bus1.req_ready, bus1.rsp_valid, bus1.rsp_data);
        end
    endtask

    // Directed cases with hand-derived data; latency and read addresses come from the model
    task automatic test_directed();
        logic [31:0] t_addr[8] = '{32'h3, 32'h7, 32'h2, 32'h7, 32'h7, 32'hFFFFFFFE, 32'h5, 32'h1};
        logic [1:0]  t_size[8] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
        logic        t_sgn[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_data[8] = '{32'h00000044, 32'hFFFFFF88, 32'h66554433, 32'hFFFF9988,
                                   32'h00009988, 32'h2211DDCC, 32'h00000000, 32'h55443322};
        logic        t_err[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] d0, d1, md;
        logic        e0, e1, me;
        int          l0, l1, ml, nrd;
        logic [29:0] wa0, wa1;
        bit          to;
        for (int i = 0; i < 8; i++) begin
            do_req(t_addr[i], t_size[i], t_sgn[i], d0, e0, l0, d1, e1, l1, to);
            ref_load(1, t_addr[i], t_size[i], t_sgn[i], md, me, ml, nrd, wa0, wa1);
            n_checks++;
            if (to || d0 !== t_data[i] || e0 !== t_err[i]) begin
                n_fail++;
                $display("FAIL directed_data[%0d]: got data=%h err=%b timeout=%0d, need data=%h err=%b",
                         i, d0, e0, to, t_data[i], t_err[i]);
            end
            n_checks++;
            if (l0 != ml) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d, need %0d", i, l0, ml);
            end
            n_checks++;
            if (rd_q0.size() != nrd || (nrd > 0 && rd_q0[0] !== wa0) || (nrd > 1 && rd_q0[1] !== wa1)) begin
                n_fail++;
                $display("FAIL directed_reads[%0d]: got %0d reads (first %h), need %0d reads %h %h",
                         i, rd_q0.size(), (rd_q0.size() > 0) ? rd_q0[0] : 30'd0, nrd, wa0, wa1);
            end
            ref_load(0, t_addr[i], t_size[i], t_sgn[i], md, me, ml, nrd, wa0, wa1);
            n_checks++;
            if (d1 !== md || e1 !== me || l1 != ml || rd_q1.size() != nrd) begin
                n_fail++;
                $display("FAIL directed_strict[%0d]: got data=%h err=%b lat=%0d reads=%0d, need %h %b %0d %0d",
                         i, d1, e1, l1, rd_q1.size(), md, me, ml, nrd);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, d0, d1, md;
        logic [1:0]  size;
        logic        sgn, e0, e1, me;
        int          l0, l1, ml, nrd, sel;
        logic [29:0] wa0, wa1;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 3);
            addr = (sel == 0) ? 32'($urandom_range(0, 15)) :
                   (sel == 1) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sgn  = 1'($urandom_range(0, 1));
            do_req(addr, size, sgn, d0, e0, l0, d1, e1, l1, to);
            ref_load(1, addr, size, sgn, md, me, ml, nrd, wa0, wa1);
            n_checks++;
            if (to || d0 !== md || e0 !== me || l0 != ml || rd_q0.size() != nrd ||
                (nrd > 0 && rd_q0[0] !== wa0) || (nrd > 1 && rd_q0[1] !== wa1)) begin
                n_fail++;
                $display("FAIL random[%0d] addr=%h size=%0d sgn=%b: got data=%h err=%b lat=%0d reads=%0d, need %h %b %0d %0d",
                         i, addr, size, sgn, d0, e0, l0, rd_q0.size(), md, me, ml, nrd);
            end
            ref_load(0, addr, size, sgn, md, me, ml, nrd, wa0, wa1);
            n_checks++;
            if (d1 !== md || e1 !== me || l1 != ml || rd_q1.size() != nrd) begin
                n_fail++;
                $display("FAIL random_strict[%0d] addr=%h size=%0d: got data=%h err=%b lat=%0d, need %h %b %0d",
                         i, addr, size, d1, e1, l1, md, me, ml);
            end
        end
        n_checks++;
        if (addr_viol != 0) begin
            n_fail++;
            $display("FAIL idle_word_addr: %0d cycles with nonzero addr while rd_en low, need 0", addr_viol);
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h7; bus0.req_size = 2'd0; bus0.req_signed = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        while (!bus0.rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        n_checks++;
        if (!bus0.rsp_valid) begin
            n_fail++;
            $display("FAIL bp_response: rsp_valid never rose, need 1");
        end
        // Second request held while the first response is stalled
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h0; bus0.req_size = 2'd2; bus0.req_signed = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 32'hFFFFFF88 || bus0.req_ready !== 1'b0 ||
                bus0.mem_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b rd_en=%b, need 1 ffffff88 0 0",
                         c, bus0.rsp_valid, bus0.rsp_data, bus0.req_ready, bus0.mem_rd_en);
            end
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
        n_checks++;
        if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b, need 0 1", bus0.rsp_valid, bus0.req_ready);
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        n_checks++;
        if (bus0.mem_rd_en !== 1'b1 || bus0.mem_word_addr !== 30'd0) begin
            n_fail++;
            $display("FAIL bp_second_accept: rd_en=%b waddr=%h, need 1 0", bus0.mem_rd_en, bus0.mem_word_addr);
        end
        guard = 0;
        while (!bus0.rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        n_checks++;
        if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 32'h44332211 || bus0.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_data: valid=%b data=%h err=%b, need 1 44332211 0",
                     bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err);
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h6; bus0.req_size = 2'd2; bus0.req_signed = 1'b0;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus0.mem_rd_en !== 1'b1 || bus0.mem_word_addr !== 30'd2) begin
            n_fail++;
            $display("FAIL mid_rd_hi: rd_en=%b waddr=%h, need 1 2", bus0.mem_rd_en, bus0.mem_word_addr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_data !== 32'd0 ||
            bus0.rsp_err !== 1'b0 || bus0.mem_rd_en !== 1'b0 || bus0.mem_word_addr !== 30'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: ready=%b valid=%b data=%h err=%b rd_en=%b waddr=%h, need 1 0 0 0 0 0",
                     bus0.req_ready, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.mem_rd_en, bus0.mem_word_addr);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus0.rsp_valid || bus0.mem_rd_en) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_rsp: %0d active cycles after reset, need 0", seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_addr = 32'd0; bus0.req_size = 2'd0;
        bus0.req_signed = 1'b0; bus0.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
